// File: rtl/alu_seq_ctrl.sv
// Sequencing controller around a 32-bit ALU op set with iterative DIV/MOD/POW.
// Define ALU_SEQ_POW_EN to build the square-and-multiply POW datapath.
module alu_seq_ctrl #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic         out_err,
  output logic         busy
);

  localparam int CNT_W = $clog2(W);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_POW = 3'b101;
  localparam logic [2:0] OP_RS  = 3'b110;
  localparam logic [2:0] OP_LS  = 3'b111;

`ifdef ALU_SEQ_POW_EN
  localparam bit POW_EN = 1'b1;
`else
  localparam bit POW_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     y_q, y_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0]     mul_x, mul_y, prod;
  logic [W:0]       div_sh;
  logic [W-1:0]     div_diff;
  logic             div_ge;
`ifdef ALU_SEQ_POW_EN
  logic [W-1:0]     sq;
`endif

  // One shared multiplier: a*b for MUL, acc*base while iterating POW.
  // Divider: acc holds the partial remainder, a shifts out dividend bits and in quotient bits.
  always_comb begin
    mul_x    = (state_q == ITER) ? acc_q : a_q;
    mul_y    = (state_q == ITER) ? a_q : b_q;
    prod     = mul_x * mul_y;
    div_sh   = {acc_q, a_q[W-1]};
    div_ge   = (div_sh >= {1'b0, b_q});
    div_diff = div_sh[W-1:0] - b_q;
`ifdef ALU_SEQ_POW_EN
    sq       = a_q * a_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    y_d     = y_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = in_op;
          a_d   = in_a;
          b_d   = in_b;
          acc_d = (in_op == OP_POW) ? W'(1) : '0;
          cnt_d = CNT_W'(W - 1);
          if (in_op == OP_DIV || in_op == OP_MOD || (in_op == OP_POW && POW_EN))
            state_d = ITER;
          else
            state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = DONE;
        err_d   = 1'b0;
        case (op_q)
          OP_ADD:  y_d = a_q + b_q;
          OP_SUB:  y_d = a_q - b_q;
          OP_MUL:  y_d = prod;
          OP_RS:   y_d = a_q >> 1;
          OP_LS:   y_d = a_q << 1;
          default: begin
            y_d   = '0;
            err_d = 1'b1;
          end
        endcase
      end
      ITER: begin
        if ((op_q == OP_DIV || op_q == OP_MOD) && b_q == '0) begin
          state_d = DONE;
          y_d     = (op_q == OP_DIV) ? '1 : a_q;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          if (op_q == OP_POW) begin
`ifdef ALU_SEQ_POW_EN
            acc_d = b_q[0] ? prod : acc_q;
            a_d   = sq;
            b_d   = b_q >> 1;
`endif
          end else begin
            acc_d = div_ge ? div_diff : div_sh[W-1:0];
            a_d   = {a_q[W-2:0], div_ge};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = DONE;
            cnt_d   = '0;
            err_d   = 1'b0;
            y_d     = (op_q == OP_DIV) ? a_d : acc_d;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_y     = y_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed steps plus random ops against a behavioural model.
// Tracks the ALU_SEQ_POW_EN build option so POW expectations match the compiled RTL.
module tb_alu_seq_ctrl;
  localparam int W = 32;

`ifdef ALU_SEQ_POW_EN
  localparam bit POW_EN = 1'b1;
`else
  localparam bit POW_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_err;
  logic         busy;

  int errors = 0;
  int checks = 0;

  alu_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: result, error flag and the cycle (accept edge = 0) at which out_valid is first seen.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] y, output logic err, output int lat);
    logic [W-1:0] p;
    err = 1'b0;
    lat = 2;
    case (op)
      3'd0: y = a + b;
      3'd1: y = a - b;
      3'd2: y = a * b;
      3'd3: begin
        if (b == 0) begin y = '1; err = 1'b1; end
        else begin y = a / b; lat = W + 1; end
      end
      3'd4: begin
        if (b == 0) begin y = a; err = 1'b1; end
        else begin y = a % b; lat = W + 1; end
      end
      3'd5: begin
        if (POW_EN) begin
          p = a ** b;
          y = p;
          lat = W + 1;
        end else begin
          y = '0;
          err = 1'b1;
        end
      end
      3'd6: y = a >> 1;
      default: y = a << 1;
    endcase
  endfunction

  // Issue one command while idle, then wait (bounded) for out_valid sampled at negedges.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic [W-1:0] y, output logic err, output int lat,
                               output logic rdy_at_done);
    @(negedge clk);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 3'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    y           = out_y;
    err         = out_err;
    rdy_at_done = in_ready;
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    logic [W-1:0] ey, y;
    logic         eerr, err, rdy;
    int           elat, lat;
    model(op, a, b, ey, eerr, elat);
    out_ready = 1'b1;
    applyStimulus(op, a, b, y, err, lat, rdy);
    checkOutput({name, " y"}, y, ey);
    checkOutput({name, " err"}, W'(err), W'(eerr));
    checkOutput({name, " latency"}, W'(lat), W'(elat));
    checkOutput({name, " in_ready while valid"}, W'(rdy), W'(0));
    @(negedge clk);
    checkOutput({name, " in_ready after handshake"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] y;
    logic         err, rdy, stale;
    int           lat;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    #1;
    checkOutput("reset in_ready", W'(in_ready), W'(1));
    checkOutput("reset out_valid", W'(out_valid), W'(0));
    checkOutput("reset out_y", out_y, '0);
    checkOutput("reset out_err", W'(out_err), W'(0));
    checkOutput("reset busy", W'(busy), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runOp("add wrap", 3'd0, 32'hFFFF_FFFF, 32'd2);
    runOp("div 100/7", 3'd3, 32'd100, 32'd7);
    runOp("mod 100%7", 3'd4, 32'd100, 32'd7);
    runOp("div by zero", 3'd3, 32'd5, 32'd0);
    runOp("mod by zero", 3'd4, 32'd5, 32'd0);
    runOp("pow 3^5", 3'd5, 32'd3, 32'd5);
    runOp("pow 2^40", 3'd5, 32'd2, 32'd40);
    runOp("pow 0^0", 3'd5, 32'd0, 32'd0);
    runOp("rs", 3'd6, 32'h8000_0001, $urandom);
    runOp("ls", 3'd7, 32'h8000_0001, $urandom);
    runOp("sub under", 3'd1, 32'd3, 32'd5);

    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
      if (i % 4 == 1) rb = 32'($urandom_range(1, 300));
      runOp($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
    end

    // Backpressure: result must hold and a second command must be ignored.
    out_ready = 1'b0;
    applyStimulus(3'd2, 32'h0001_0000, 32'h0001_0000, y, err, lat, rdy);
    checkOutput("bp mul y", y, '0);
    checkOutput("bp mul latency", W'(lat), W'(2));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_a     = 32'd1;
      in_b     = 32'd1;
      @(negedge clk);
      checkOutput($sformatf("bp hold y c%0d", i), out_y, '0);
      checkOutput($sformatf("bp hold valid/ready c%0d", i), W'({out_valid, in_ready}), W'(2'b10));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp release out_valid", W'(out_valid), W'(0));
    checkOutput("bp release in_ready", W'(in_ready), W'(1));
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || busy) stale = 1'b1;
    end
    checkOutput("bp ignored command", W'(stale), W'(0));

    // Asynchronous reset in the middle of a DIV.
    @(negedge clk);
    in_op    = 3'd3;
    in_a     = 32'd1000;
    in_b     = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("mid-div busy before reset", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", W'(busy), W'(0));
    checkOutput("abort out_valid", W'(out_valid), W'(0));
    checkOutput("abort in_ready", W'(in_ready), W'(1));
    checkOutput("abort out_y", out_y, '0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) stale = 1'b1;
    end
    checkOutput("no stale result after abort", W'(stale), W'(0));
    runOp("add after abort", 3'd0, 32'd1234, 32'd4321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
